// File: rtl/rr_mux4_arbiter_if.sv
// rtl/rr_mux4_arbiter_if.sv - request/data/grant bundle between four producers, the arbiter and the consumer
interface rr_mux4_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [3:0]       gnt;
    logic [1:0]       s;
    logic             busy;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    // Producer/consumer side: drives requests and data, observes grant and shared output.
    modport master (
        output req, a, b, c, d,
        input  gnt, s, busy, out, out_valid
    );

    // Arbiter side.
    modport slave (
        input  req, a, b, c, d,
        output gnt, s, busy, out, out_valid
    );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// rtl/rr_mux4_arbiter.sv - round-robin arbiter sharing one 4:1 mux with a bounded hold time
module rr_mux4_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    rr_mux4_arbiter_if.slave  bus
);
    localparam logic [7:0] LP_HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_s;
    logic [3:0]       r_gnt;
    logic [1:0]       r_ptr;
    logic [7:0]       r_cnt;

    logic             w_busy;
    logic             w_release;
    logic [1:0]       w_win_idle;
    logic [1:0]       w_win_next;
    logic [WIDTH-1:0] w_out;

    // First set bit of r searching p, p+1, p+2, p+3 (mod 4); later iterations have higher priority.
    function automatic logic [1:0] win(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        win = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) win = idx;
        end
    endfunction

    assign w_busy     = (r_state == ST_GRANT);
    assign w_release  = !bus.req[r_s] || (r_cnt == LP_HOLD_LAST);
    assign w_win_idle = win(bus.req, r_ptr);
    assign w_win_next = win(bus.req, r_s + 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_s     <= 2'b00;
            r_gnt   <= 4'b0000;
            r_ptr   <= 2'b00;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        r_state <= ST_GRANT;
                        r_s     <= w_win_idle;
                        r_gnt   <= 4'b0001 << w_win_idle;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_gnt   <= 4'b0000;
                    end
                end
                ST_GRANT: begin
                    if (!w_release) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else begin
                        r_ptr <= r_s + 2'd1;
                        r_cnt <= 8'd0;
                        // A lone timed-out requester wins its own handover and is re-granted.
                        if (|bus.req) begin
                            r_s   <= w_win_next;
                            r_gnt <= 4'b0001 << w_win_next;
                        end else begin
                            r_state <= ST_IDLE;
                            r_gnt   <= 4'b0000;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                end
            endcase
        end
    end

    always_comb begin
        w_out = '0;
        if (w_busy) begin
            case (r_s)
                2'd0:    w_out = bus.a;
                2'd1:    w_out = bus.b;
                2'd2:    w_out = bus.c;
                default: w_out = bus.d;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.s         = r_s;
    assign bus.busy      = w_busy;
    assign bus.out       = w_out;
    assign bus.out_valid = w_busy & bus.req[r_s];
endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// tb/tb_rr_mux4_arbiter.sv - directed-vector bench for rr_mux4_arbiter at hold limits 4, 2 and 1
module tb_rr_mux4_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    rr_mux4_arbiter_if #(.WIDTH(8)) if4 ();
    rr_mux4_arbiter_if #(.WIDTH(8)) if2 ();
    rr_mux4_arbiter_if #(.WIDTH(8)) if1 ();

    rr_mux4_arbiter #(.WIDTH(8), .MAX_HOLD(4)) u_h4 (.clk(clk), .rst(rst), .bus(if4));
    rr_mux4_arbiter #(.WIDTH(8), .MAX_HOLD(2)) u_h2 (.clk(clk), .rst(rst), .bus(if2));
    rr_mux4_arbiter #(.WIDTH(8), .MAX_HOLD(1)) u_h1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_s2 [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    logic [1:0] exp_s1 [6]  = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3};
    logic [7:0] data_of [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    initial begin
        if4.req = 4'b0; if2.req = 4'b0; if1.req = 4'b0;
        if4.a = 8'hA0; if4.b = 8'hB1; if4.c = 8'hC2; if4.d = 8'hD3;
        if2.a = 8'hA0; if2.b = 8'hB1; if2.c = 8'hC2; if2.d = 8'hD3;
        if1.a = 8'hA0; if1.b = 8'hB1; if1.c = 8'hC2; if1.d = 8'hD3;

        tick();
        rst = 1'b0;
        check("rst_gnt",  32'(if4.gnt), 32'h0);
        check("rst_s",    32'(if4.s), 32'h0);
        check("rst_busy", 32'(if4.busy), 32'h0);
        check("rst_out",  32'(if4.out), 32'h0);
        check("rst_ov",   32'(if4.out_valid), 32'h0);

        // Single requester a, hold limit 4: grant, time out, re-grant.
        if4.req = 4'b0001;
        tick();
        check("t1_gnt",  32'(if4.gnt), 32'h1);
        check("t1_s",    32'(if4.s), 32'h0);
        check("t1_out",  32'(if4.out), 32'hA0);
        check("t1_ov",   32'(if4.out_valid), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_hold_gnt",  32'(if4.gnt), 32'h1);
            check("t1_hold_busy", 32'(if4.busy), 32'h1);
        end
        // Re-grant restarted cnt at 0, so b waits three more cycles.
        if4.req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_regrant_gnt", 32'(if4.gnt), 32'h1);
        end
        tick();
        check("t1_handover_gnt", 32'(if4.gnt), 32'h2);
        check("t1_handover_s",   32'(if4.s), 32'h1);
        check("t1_handover_out", 32'(if4.out), 32'hB1);

        // Release of b to idle.
        if4.req = 4'b0000;
        tick();
        check("t3_busy", 32'(if4.busy), 32'h0);
        check("t3_gnt",  32'(if4.gnt), 32'h0);
        check("t3_s",    32'(if4.s), 32'h1);
        check("t3_out",  32'(if4.out), 32'h0);
        check("t3_ov",   32'(if4.out_valid), 32'h0);

        // ptr=2 after b released: c beats a.
        if4.req = 4'b0101;
        tick();
        check("t4_s",   32'(if4.s), 32'h2);
        check("t4_gnt", 32'(if4.gnt), 32'h4);
        check("t4_out", 32'(if4.out), 32'hC2);

        // Move grant to d, let cnt reach 2, then reset mid-grant.
        if4.req = 4'b1000;
        tick();
        check("t5_gnt_d", 32'(if4.gnt), 32'h8);
        check("t5_s_d",   32'(if4.s), 32'h3);
        tick();
        tick();
        check("t5_pre_rst_gnt", 32'(if4.gnt), 32'h8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_gnt",  32'(if4.gnt), 32'h0);
        check("t5_rst_s",    32'(if4.s), 32'h0);
        check("t5_rst_busy", 32'(if4.busy), 32'h0);
        check("t5_rst_ov",   32'(if4.out_valid), 32'h0);
        check("t5_rst_out",  32'(if4.out), 32'h0);
        tick();
        check("t5_regnt_gnt", 32'(if4.gnt), 32'h8);
        check("t5_regnt_s",   32'(if4.s), 32'h3);
        check("t5_regnt_out", 32'(if4.out), 32'hD3);
        if4.req = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_cnt_gnt", 32'(if4.gnt), 32'h8);
        end
        tick();
        check("t5_to_a_gnt", 32'(if4.gnt), 32'h1);
        check("t5_to_a_out", 32'(if4.out), 32'hA0);
        if4.req = 4'b0000;
        tick();

        // Hold limit 2, all requesting: pairs in rotation, no gaps.
        if2.req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_s",    32'(if2.s), 32'(exp_s2[i]));
            check("t2_gnt",  32'(if2.gnt), 32'(4'b0001 << exp_s2[i]));
            check("t2_busy", 32'(if2.busy), 32'h1);
        end
        if2.req = 4'b0000;
        tick();
        check("t2_idle_busy", 32'(if2.busy), 32'h0);

        // Hold limit 1, b and d requesting: alternate every cycle.
        if1.req = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_s",   32'(if1.s), 32'(exp_s1[i]));
            check("t6_ov",  32'(if1.out_valid), 32'h1);
            check("t6_out", 32'(if1.out), 32'(data_of[exp_s1[i]]));
        end
        if1.req = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 data mux between four requesters (a, b, c, d).
- Holds the 2-bit select for the duration of a grant, bounded by a programmable hold limit.
- Drives the shared output with the granted requester's data.
- Sits between four producer blocks and a single downstream consumer.

Parameters:
- WIDTH, 8, data width of each requester's input and of out.
- MAX_HOLD, 4, maximum consecutive cycles one grant may last; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request vector; bit0=a, bit1=b, bit2=c, bit3=d.
- a  input  WIDTH  requester 0 data.
- b  input  WIDTH  requester 1 data.
- c  input  WIDTH  requester 2 data.
- d  input  WIDTH  requester 3 data.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- s  output  2  registered mux select; 00=a, 01=b, 10=c, 11=d.
- busy  output  1  registered; 1 while a grant is active.
- out  output  WIDTH  shared mux output.
- out_valid  output  1  high when a grant is active and the granted requester's req bit is high.

Behaviour:
- Reset: when rst is sampled high at a clock edge, all of the following take their reset values, regardless of current state (this covers reset mid-grant):
  - gnt=0000, s=00, busy=0, priority pointer ptr=00, hold counter cnt=0, state=IDLE.
  - out=0 and out_valid=0 in the cycle following the reset edge.
- States: IDLE and GRANT. busy=1 exactly when the state is GRANT.
- Arbitration function win(req, p): the first requester with req set, searching indices p, p+1, p+2, p+3, each taken mod 4.
- IDLE behaviour:
  - If req != 0 at an edge: next state is GRANT, s=win(req,ptr), gnt=onehot(s), cnt=0.
  - Otherwise remain in IDLE; gnt=0 and s keeps its previous value.
  - Latency from req asserted to gnt asserted is 1 cycle.
- GRANT release condition: at an edge, the grant is released when req[s]==0 OR cnt==MAX_HOLD-1.
- GRANT, no release: stay in GRANT, cnt=cnt+1, s and gnt unchanged.
- GRANT, release: ptr=s+1 mod 4, so the releasing requester becomes lowest priority.
  - If req has any bit set: stay in GRANT, s=win(req, s+1), cnt=0. This is a direct handover with no idle bubble.
  - If the releasing requester is the only one still requesting (timeout case), it is re-granted with cnt=0.
  - If req==0: next state is IDLE and gnt=0000.
- cnt width is 8 bits. It never exceeds MAX_HOLD-1 and does not wrap.
- MAX_HOLD=1: every grant lasts exactly 1 cycle, so continuous requesters rotate each cycle.
- Datapath (combinational from registered s and gnt):
  - out = the data selected by s when busy=1, else 0.
  - out_valid = busy & req[s].
- Requests are level-sensitive. A requester dropping req while not granted is simply skipped.
- A req that arrives in the same cycle as a release takes part in that handover.
- gnt is always one-hot or zero; it never has more than one bit set.
- ptr changes only on release, never during IDLE.

Test Plan:
1. Reset, then req=0001 held with MAX_HOLD=4 -> gnt=0001 and s=00 one cycle later; out=a and out_valid=1. At cnt=3 the grant times out and is immediately re-granted (gnt stays 0001, cnt returns to 0).
2. req=1111 held, MAX_HOLD=2 -> grant order a,a,b,b,c,c,d,d,a,a; each change in s occurs with no gap in busy.
3. Grant on b (req=0010), then req changes to 0000 -> at the next edge busy=0 and gnt=0000; s stays 01; out=0.
4. ptr=2 after a release of b, then req=0101 -> winner is c (s=10), not a.
5. rst asserted for one cycle mid-grant on d with cnt=2 -> next cycle gnt=0000, s=00, busy=0, out_valid=0. Then req=1000 -> d is granted with cnt starting from 0.
6. MAX_HOLD=1, req=1010 -> s alternates 01,11,01,11 every cycle; out_valid stays 1 throughout.
